// File: rtl/bus_unpacker_pkg.sv
// Shared widths, types and helpers for the 5-bit to 6-bit receive gearbox.
package bus_link_pkg;

   localparam int LINK_IN_W  = 5;
   localparam int LINK_OUT_W = 6;
   localparam int LINK_ACC_W = 10;

   typedef logic [LINK_IN_W-1:0]  sym_t;
   typedef logic [LINK_OUT_W-1:0] word_t;
   typedef logic [3:0]            fill_t;
   typedef logic [LINK_ACC_W-1:0] acc_t;

   localparam fill_t IN_CNT  = 4'd5;
   localparam fill_t OUT_CNT = 4'd6;

   // Place a symbol into the accumulator so that its bit 0 lands at bit position pos.
   function automatic acc_t place_sym(input sym_t sym, input fill_t pos);
      acc_t wide;
      wide = {5'd0, sym};
      return wide << pos;
   endfunction

endpackage

// File: rtl/bus_unpacker_if.sv
// Valid/ready symbol input and word output bundle of the receive gearbox.
interface bus_unpacker_if;
   import bus_link_pkg::*;

   logic  in_valid;
   sym_t  in_data;
   logic  in_ready;
   logic  out_valid;
   word_t out_data;
   logic  out_ready;
   fill_t fill;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, fill
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, fill
   );

endinterface

// File: rtl/bus_unpacker.sv
// Reassembles LSB-first 5-bit symbols into 6-bit words through a 10-bit accumulator.
module bus_unpacker
   import bus_link_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   bus_unpacker_if.slave bus
);

   acc_t  acc_q;
   acc_t  acc_d;
   acc_t  acc_base_s;
   fill_t cnt_q;
   fill_t cnt_d;
   fill_t cnt_base_s;
   logic  out_valid_s;
   logic  in_ready_s;
   logic  push_s;
   logic  pop_s;

   // out_ready reaches in_ready combinationally so a full buffer can drain and refill in one cycle.
   assign out_valid_s = (cnt_q >= OUT_CNT);
   assign in_ready_s  = !clear && ((cnt_q < OUT_CNT) || bus.out_ready);
   assign push_s      = bus.in_valid && in_ready_s;
   assign pop_s       = out_valid_s && bus.out_ready && !clear;

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = acc_q[LINK_OUT_W-1:0];
   assign bus.fill      = cnt_q;

   // Next accumulator contents: retire a word first, then merge the new symbol above what remains.
   always_comb begin
      acc_base_s = acc_q;
      cnt_base_s = cnt_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      if (pop_s) begin
         acc_base_s = acc_q >> LINK_OUT_W;
         cnt_base_s = cnt_q - OUT_CNT;
      end else begin
         acc_base_s = acc_q;
         cnt_base_s = cnt_q;
      end
      if (clear) begin
         acc_d = 10'd0;
         cnt_d = 4'd0;
      end else if (push_s) begin
         acc_d = acc_base_s | place_sym(bus.in_data, cnt_base_s);
         cnt_d = cnt_base_s + IN_CNT;
      end else begin
         acc_d = acc_base_s;
         cnt_d = cnt_base_s;
      end
   end

   // Accumulator and bit-count state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= 10'd0;
         cnt_q <= 4'd0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bus_unpacker.sv
// Self-checking bench: directed vector table, async reset sequence and a random soak against a bit-queue model.
module tb_bus_unpacker;
   import bus_link_pkg::*;

   logic clk;
   logic reset_n;
   logic clear;
   int   checks;
   int   errors;

   bus_unpacker_if bus ();

   bus_unpacker dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       clr;
      logic       iv;
      logic [4:0] d;
      logic       ordy;
      logic       e_ir;
      logic       e_ov;
      logic [5:0] e_od;
      logic [3:0] e_f;
   } vec_t;

   vec_t vecs[$];
   bit   mq[$];

   function automatic vec_t mk(input logic c, input logic iv, input logic [4:0] d, input logic o,
                               input logic ir, input logic ov, input logic [5:0] od, input logic [3:0] f);
      vec_t v;
      v = '{c, iv, d, o, ir, ov, od, f};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic c, input logic iv, input logic [4:0] d, input logic o);
      clear        = c;
      bus.in_valid = iv;
      bus.in_data  = d;
      bus.out_ready = o;
   endtask

   // One cycle compared against the bit-queue model, which is then advanced by the same handshakes.
   task automatic model_cycle(input logic c, input logic iv, input logic [4:0] d, input logic o,
                              output logic pushed);
      logic       m_ir;
      logic       m_ov;
      logic [5:0] m_od;
      drive(c, iv, d, o);
      @(negedge clk);
      m_ov = (mq.size() >= 6);
      m_ir = !c && ((mq.size() < 6) || o);
      for (int i = 0; i < 6; i++) m_od[i] = (i < mq.size()) ? mq[i] : 1'b0;
      check("soak_in_ready", {31'd0, bus.in_ready}, {31'd0, m_ir});
      check("soak_out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
      check("soak_out_data", {26'd0, bus.out_data}, {26'd0, m_od});
      check("soak_fill", {28'd0, bus.fill}, mq.size());
      if (bus.fill > 4'd10) check("soak_fill_max", {28'd0, bus.fill}, 32'd10);
      @(posedge clk);
      #1;
      pushed = 1'b0;
      if (c) begin
         mq.delete();
      end else begin
         if (m_ov && o) repeat (6) void'(mq.pop_front());
         if (iv && m_ir) begin
            for (int i = 0; i < 5; i++) mq.push_back(d[i]);
            pushed = 1'b1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic pushed;
      int   n_sym;
      int   cyc;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 5'd0, 1'b0);
      #12;
      check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_fill", {28'd0, bus.fill}, 32'd0);
      check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset_out_data", {26'd0, bus.out_data}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // clr, iv, data, out_ready | in_ready, out_valid, out_data, fill (state before the edge)
      vecs.push_back(mk(1'b0, 1'b1, 5'h01, 1'b1, 1'b1, 1'b0, 6'h00, 4'd0));
      vecs.push_back(mk(1'b0, 1'b1, 5'h02, 1'b1, 1'b1, 1'b0, 6'h01, 4'd5));
      vecs.push_back(mk(1'b0, 1'b1, 5'h03, 1'b1, 1'b1, 1'b1, 6'h01, 4'd10));
      vecs.push_back(mk(1'b0, 1'b1, 5'h04, 1'b1, 1'b1, 1'b1, 6'h31, 4'd9));
      vecs.push_back(mk(1'b0, 1'b1, 5'h05, 1'b1, 1'b1, 1'b1, 6'h20, 4'd8));
      vecs.push_back(mk(1'b0, 1'b1, 5'h06, 1'b1, 1'b1, 1'b1, 6'h14, 4'd7));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 6'h0C, 4'd6));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b0, 6'h00, 4'd0));
      vecs.push_back(mk(1'b0, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b0, 6'h00, 4'd0));
      vecs.push_back(mk(1'b0, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b0, 6'h1F, 4'd5));
      vecs.push_back(mk(1'b0, 1'b1, 5'h1F, 1'b0, 1'b0, 1'b1, 6'h3F, 4'd10));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 6'h3F, 4'd10));
      vecs.push_back(mk(1'b1, 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0, 6'h0F, 4'd4));
      vecs.push_back(mk(1'b0, 1'b1, 5'h15, 1'b1, 1'b1, 1'b0, 6'h00, 4'd0));
      vecs.push_back(mk(1'b1, 1'b1, 5'h1F, 1'b1, 1'b0, 1'b0, 6'h15, 4'd5));
      vecs.push_back(mk(1'b0, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b0, 6'h00, 4'd0));
      vecs.push_back(mk(1'b0, 1'b1, 5'h1F, 1'b0, 1'b1, 1'b0, 6'h1F, 4'd5));
      vecs.push_back(mk(1'b0, 1'b1, 5'h00, 1'b1, 1'b1, 1'b1, 6'h3F, 4'd10));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b0, 1'b0, 1'b1, 6'h0F, 4'd9));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b1, 1'b1, 1'b1, 6'h0F, 4'd9));
      vecs.push_back(mk(1'b1, 1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 6'h00, 4'd3));
      vecs.push_back(mk(1'b0, 1'b0, 5'h00, 1'b0, 1'b1, 1'b0, 6'h00, 4'd0));

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_ir});
         check($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, vecs[i].e_ov});
         check($sformatf("vec%0d_out_data", i), {26'd0, bus.out_data}, {26'd0, vecs[i].e_od});
         check($sformatf("vec%0d_fill", i), {28'd0, bus.fill}, {28'd0, vecs[i].e_f});
         @(posedge clk);
         #1;
      end

      // Build up fill=7, then pull reset between edges.
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 5'($urandom), 1'b1);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 1'b0, 5'd0, 1'b0);
      #1;
      check("pre_reset_fill", {28'd0, bus.fill}, 32'd7);
      reset_n = 1'b0;
      #1;
      check("async_reset_fill", {28'd0, bus.fill}, 32'd0);
      check("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("async_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      mq.delete();
      n_sym = 0;
      cyc   = 0;
      while (n_sym < 1000 && cyc < 20000) begin
         model_cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                     5'($urandom), ($urandom_range(0, 99) < 70), pushed);
         if (pushed) n_sym++;
         cyc++;
      end
      check("soak_symbols", n_sym, 32'd1000);
      for (int i = 0; i < 4; i++) model_cycle(1'b0, 1'b0, 5'd0, 1'b1, pushed);
      check("drain_fill", {28'd0, bus.fill}, mq.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
